banked_mem: RTL



---
 rtl/banked_mem_if.sv | 22 ++
 rtl/banked_mem.sv | 115 +++++++++++
 2 files changed

// File: rtl/banked_mem_if.sv
// Request/response bus between the cache controller and banked_mem.
interface banked_mem_if;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        rd;
    logic        wr;
    logic [15:0] data_out;
    logic        rd_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    modport master (
        output addr, data_in, rd, wr,
        input  data_out, rd_valid, stall, busy, err
    );

    modport slave (
        input  addr, data_in, rd, wr,
        output data_out, rd_valid, stall, busy, err
    );
endinterface

// File: rtl/banked_mem.sv
// Four-bank word-interleaved memory: bank = addr[2:1], word = addr[15:3].
// Each accepted access occupies its bank for BUSY_CYC cycles; reads return
// through a fixed two-stage pipeline. Define BANKED_MEM_ERR_EN to reject
// odd addresses and rd&wr collisions with an err flag.
module banked_mem #(
    parameter int unsigned BUSY_CYC       = 4,
    parameter int unsigned WORDS_PER_BANK = 8192
) (
    input logic         clk,
    input logic         rst,
    banked_mem_if.slave bus
);

    localparam logic [3:0] CntLoad = 4'(BUSY_CYC - 1);

    logic [1:0]  bank;
    logic [12:0] word;
    logic        req;
    logic        err;
    logic        accept;
    logic [3:0]  busy;

    logic [3:0]  cnt_q [4];
    logic [3:0]  cnt_d [4];

    logic [15:0] mem_q [4][WORDS_PER_BANK];

    logic [15:0] s1_data_q;
    logic        s1_valid_q, s1_valid_d;
    logic [15:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;

    assign bank = bus.addr[2:1];
    assign word = bus.addr[15:3];
    assign req  = bus.rd ^ bus.wr;

`ifdef BANKED_MEM_ERR_EN
    assign err = (bus.rd & bus.wr) | ((bus.rd | bus.wr) & bus.addr[0]);
`else
    // Odd addresses alias the even word; rd&wr is dropped silently.
    logic unused_addr0;
    assign unused_addr0 = bus.addr[0];
    assign err = 1'b0;
`endif

    // Bank occupancy decoded from the per-bank counters.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            busy[b] = (cnt_q[b] != 4'd0);
        end
    end

    // Illegal requests neither stall nor access the array.
    assign bus.stall = req & ~err & busy[bank];
    assign accept    = req & ~err & ~busy[bank];
    assign bus.err   = err;
    assign bus.busy  = busy;

    // Load the counter on accept, otherwise count down to zero and hold.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            cnt_d[b] = cnt_q[b];
            if (accept && (bank == 2'(b))) begin
                cnt_d[b] = CntLoad;
            end else if (cnt_q[b] != 4'd0) begin
                cnt_d[b] = cnt_q[b] - 4'd1;
            end
        end
    end

    // Busy counters.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (rst) begin
                cnt_q[b] <= 4'd0;
            end else begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    // Read pipeline next state; output data is forced to zero when not valid.
    always_comb begin
        s1_valid_d  = accept & bus.rd;
        out_valid_d = s1_valid_q;
        out_data_d  = s1_valid_q ? s1_data_q : 16'h0000;
    end

    // Read pipeline valid/output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Bank array and stage-1 read register; not reset, so a write in a reset cycle still lands.
    always_ff @(posedge clk) begin
        if (accept && bus.wr) begin
            mem_q[bank][word] <= bus.data_in;
        end
        if (accept && bus.rd) begin
            s1_data_q <= mem_q[bank][word];
        end
    end

    assign bus.data_out = out_data_q;
    assign bus.rd_valid = out_valid_q;

endmodule
